// File: rtl/tc0200obj_ext_arbiter.sv
// Arbitrates the tile-code extension RAM between the object engine, the CPU and savestate.
// Every RAM access runs IDLE->ACC->DONE->IDLE; passthrough object lookups answer straight from IDLE.
module tc0200obj_ext_arbiter #(
  parameter int RAM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic              obj_req,
  output logic              obj_ack,
  input  logic [RAM_AW-1:0] obj_addr,
  input  logic [13:0]       obj_code,
  output logic [19:0]       obj_code_out,
  input  logic              cpu_cs,
  input  logic              cpu_rw,
  input  logic [1:0]        cpu_ds_n,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  output logic              cpu_ack,
  output logic [15:0]       cpu_dout,
  input  logic              ss_req,
  input  logic              ss_we,
  input  logic [RAM_AW-1:0] ss_addr,
  input  logic [7:0]        ss_wdata,
  output logic              ss_ack,
  output logic [7:0]        ss_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_q
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  typedef enum logic [1:0] {SRC_OBJ, SRC_CPU, SRC_SS} src_t;

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t           state, state_nxt;
  src_t             src;
  logic [CNT_W-1:0] starve_cnt;
  logic [7:0]       code_lo_p0;
  logic             extend, cpu_wr, any_ack, cpu_force;
  logic             gnt_obj, gnt_cpu, gnt_ss;
  logic             unused_bits;

  assign extend  = (mode == 2'b01);
  assign cpu_wr  = ~cpu_rw & ~cpu_ds_n[0];
  assign any_ack = obj_ack | cpu_ack | ss_ack;

  // Only the low byte lane is wired to the 8-bit RAM.
  assign unused_bits = ^{cpu_din[15:8], cpu_ds_n[1]};

  // The ack cycle is an arbitration bubble: the acked requester is masked, and
  // holding the others back too lets a still-held obj_req compete again next
  // cycle, so the starvation counter alone decides when the CPU breaks in.
  always_comb begin
    state_nxt = state;
    gnt_obj   = 1'b0;
    gnt_cpu   = 1'b0;
    gnt_ss    = 1'b0;
    cpu_force = cpu_cs && (starve_cnt == STARVE_LIM);
    case (state)
      IDLE: begin
        if (!any_ack) begin
          if (cpu_force)    gnt_cpu = 1'b1;
          else if (obj_req) gnt_obj = 1'b1;
          else if (cpu_cs)  gnt_cpu = 1'b1;
          else if (ss_req)  gnt_ss  = 1'b1;
        end
        if (gnt_cpu || gnt_ss || (gnt_obj && extend)) state_nxt = ACC;
      end
      ACC:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      src          <= SRC_OBJ;
      starve_cnt   <= '0;
      ram_addr     <= '0;
      ram_we       <= 1'b0;
      obj_ack      <= 1'b0;
      cpu_ack      <= 1'b0;
      ss_ack       <= 1'b0;
      obj_code_out <= '0;
      cpu_dout     <= '0;
      ss_rdata     <= '0;
    end else begin
      state   <= state_nxt;
      obj_ack <= 1'b0;
      cpu_ack <= 1'b0;
      ss_ack  <= 1'b0;
      if (!cpu_cs || gnt_cpu)
        starve_cnt <= '0;
      else if (gnt_obj && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + CNT_W'(1);
      // grant edge: mode is sampled here only, so later mode changes wait for the next grant
      if (gnt_obj) begin
        src <= SRC_OBJ;
        if (extend) begin
          ram_addr <= obj_addr;
        end else begin
          obj_ack      <= 1'b1;
          obj_code_out <= {6'd0, obj_code};
        end
      end
      if (gnt_cpu) begin
        src      <= SRC_CPU;
        ram_addr <= cpu_addr;
        ram_we   <= cpu_wr;
      end
      if (gnt_ss) begin
        src      <= SRC_SS;
        ram_addr <= ss_addr;
        ram_we   <= ss_we;
      end
      if (state == ACC) ram_we <= 1'b0;
      // DONE->IDLE edge: ram_q now holds the byte addressed during ACC
      if (state == DONE) begin
        case (src)
          SRC_OBJ: begin
            obj_ack      <= 1'b1;
            obj_code_out <= {4'd0, ram_q, code_lo_p0};
          end
          SRC_CPU: begin
            cpu_ack  <= 1'b1;
            cpu_dout <= {ram_q, ram_q};
          end
          default: begin
            ss_ack   <= 1'b1;
            ss_rdata <= ram_q;
          end
        endcase
      end
    end
  end

  // Operand capture at grant so requesters may drop their inputs mid-access.
  always_ff @(posedge clk) begin
    if (gnt_obj) code_lo_p0 <= obj_code[7:0];
    if (gnt_cpu) ram_wdata  <= cpu_din[7:0];
    if (gnt_ss)  ram_wdata  <= ss_wdata;
  end

endmodule

// File: tb/tb_tc0200obj_ext_arbiter.sv
// Scoreboard bench for tc0200obj_ext_arbiter: expected acks are queued at request time
// and popped as acks appear; a behavioural read-first RAM sits on the RAM port.
module tb_tc0200obj_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mode;
  logic        obj_req, obj_ack;
  logic [11:0] obj_addr;
  logic [13:0] obj_code;
  logic [19:0] obj_code_out;
  logic        cpu_cs, cpu_rw, cpu_ack;
  logic [1:0]  cpu_ds_n;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_din, cpu_dout;
  logic        ss_req, ss_we, ss_ack;
  logic [11:0] ss_addr;
  logic [7:0]  ss_wdata, ss_rdata;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_q;

  logic [7:0]  mem [0:4095];

  always #5 clk = ~clk;

  tc0200obj_ext_arbiter dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .obj_req(obj_req), .obj_ack(obj_ack), .obj_addr(obj_addr), .obj_code(obj_code),
    .obj_code_out(obj_code_out),
    .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_ds_n(cpu_ds_n), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
    .ss_ack(ss_ack), .ss_rdata(ss_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    int          src;
    logic [19:0] data;
    bit          chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   we_cnt  = 0;
  logic p_obj = 1'b0, p_cpu = 1'b0, p_ss = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int src, input logic [19:0] data, input bit cd);
    exp_t e;
    e.src = src; e.data = data; e.chk_data = cd;
    sb.push_back(e);
  endtask

  // One clock; outputs sampled 1ns after the rising edge.
  task automatic step();
    exp_t        e;
    int          src;
    logic [19:0] got;
    @(posedge clk); #1;
    if (ram_we) we_cnt++;
    if (obj_ack | cpu_ack | ss_ack) begin
      check("ack_onehot", $countones({obj_ack, cpu_ack, ss_ack}), 1);
      check("ack_width", {obj_ack & p_obj, cpu_ack & p_cpu, ss_ack & p_ss}, 0);
      if (sb.size() == 0) begin
        check("unexpected_ack", {obj_ack, cpu_ack, ss_ack}, 0);
      end else begin
        e   = sb.pop_front();
        src = obj_ack ? 0 : (cpu_ack ? 1 : 2);
        got = obj_ack ? obj_code_out : (cpu_ack ? {4'd0, cpu_dout} : {12'd0, ss_rdata});
        check("ack_src", src, e.src);
        if (e.chk_data) check("ack_data", got, e.data);
      end
    end
    p_obj = obj_ack; p_cpu = cpu_ack; p_ss = ss_ack;
  endtask

  task automatic wait_ack(input int which, output int lat);
    logic a;
    lat = 0; a = 1'b0;
    while (!a && lat < 40) begin
      step();
      lat++;
      a = (which == 0) ? obj_ack : ((which == 1) ? cpu_ack : ss_ack);
    end
    if (!a) check("ack_timeout", a, 1);
  endtask

  task automatic do_obj(input logic [11:0] addr, input logic [13:0] code,
                        input logic [19:0] exp, input int exp_lat, input string tag);
    int lat;
    obj_req = 1'b1; obj_addr = addr; obj_code = code;
    push(0, exp, 1'b1);
    wait_ack(0, lat);
    obj_req = 1'b0;
    check(tag, lat, exp_lat);
    step();
  endtask

  task automatic do_cpu(input logic rw, input logic [1:0] ds_n, input logic [11:0] addr,
                        input logic [15:0] din, input logic [15:0] exp, input bit cd,
                        input string tag);
    int lat;
    cpu_cs = 1'b1; cpu_rw = rw; cpu_ds_n = ds_n; cpu_addr = addr; cpu_din = din;
    push(1, {4'd0, exp}, cd);
    wait_ack(1, lat);
    cpu_cs = 1'b0;
    check(tag, lat, 3);
    step();
  endtask

  task automatic do_ss(input logic we, input logic [11:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp, input bit cd, input string tag);
    int lat;
    ss_req = 1'b1; ss_we = we; ss_addr = addr; ss_wdata = wdata;
    push(2, {12'd0, exp}, cd);
    wait_ack(2, lat);
    ss_req = 1'b0;
    check(tag, lat, 3);
    step();
  endtask

  logic [11:0] pre_a [6] = '{12'h123, 12'h200, 12'h250, 12'h300, 12'h301, 12'h011};
  logic [7:0]  pre_d [6] = '{8'hA5, 8'hC3, 8'h11, 8'h3C, 8'h96, 8'h33};

  initial begin
    int w0, lat, n, guard, nobj;
    bit done;
    reset_n = 1'b0; mode = 2'b00;
    obj_req = 1'b0; obj_addr = '0; obj_code = '0;
    cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_ds_n = 2'b11; cpu_addr = '0; cpu_din = '0;
    ss_req = 1'b0; ss_we = 1'b0; ss_addr = '0; ss_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_acks", {obj_ack, cpu_ack, ss_ack}, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_obj_code_out", obj_code_out, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_ss_rdata", ss_rdata, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // preload through the savestate port; the first grant lands on the first edge after release
    for (int i = 0; i < 6; i++) begin
      do_ss(1'b1, pre_a[i], pre_d[i], 8'h00, 1'b0, "ss_wr_lat");
      check("ss_wr_mem", mem[pre_a[i]], pre_d[i]);
    end

    w0 = we_cnt;
    mode = 2'b00;
    do_obj(12'h055, 14'h1234, 20'h01234, 1, "pt_lat");
    mode = 2'b10;
    do_obj(12'h123, 14'h2ABC, 20'h02ABC, 1, "pt_mode2_lat");
    check("pt_no_we", we_cnt - w0, 0);

    // extend lookup with a mode change while the access is in flight
    mode = 2'b01;
    obj_req = 1'b1; obj_addr = 12'h123; obj_code = 14'h3F7C;
    push(0, 20'h0A57C, 1'b1);
    step();
    mode = 2'b00;
    obj_req = 1'b0;
    wait_ack(0, lat);
    check("ext_lat", lat + 1, 3);
    step();
    mode = 2'b01;
    do_obj(12'h301, 14'h0155, 20'h09655, 3, "ext_lat2");

    do_cpu(1'b0, 2'b00, 12'h010, 16'h055A, 16'h0000, 1'b0, "cpu_wr_lat");
    check("cpu_wr_mem", mem[12'h010], 8'h5A);
    do_cpu(1'b1, 2'b00, 12'h010, 16'h0000, 16'h5A5A, 1'b1, "cpu_rd_lat");
    w0 = we_cnt;
    do_cpu(1'b0, 2'b01, 12'h011, 16'h00FF, 16'h0000, 1'b0, "cpu_nowr_lat");
    check("cpu_ds_no_we", we_cnt - w0, 0);
    check("cpu_ds_mem", mem[12'h011], 8'h33);
    do_cpu(1'b1, 2'b00, 12'h011, 16'h0000, 16'h3333, 1'b1, "cpu_rd2_lat");
    do_ss(1'b0, 12'h200, 8'h00, 8'hC3, 1'b1, "ss_rd_lat");
    check("cpu_dout_hold", cpu_dout, 16'h3333);
    check("ss_rdata_hold", ss_rdata, 8'hC3);

    // all three requesters in the same cycle
    mode = 2'b01;
    obj_req = 1'b1; obj_addr = 12'h123; obj_code = 14'h3F7C;
    cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_ds_n = 2'b00; cpu_addr = 12'h010;
    ss_req = 1'b1; ss_we = 1'b0; ss_addr = 12'h200;
    push(0, 20'h0A57C, 1'b1);
    push(1, 20'h05A5A, 1'b1);
    push(2, 20'h000C3, 1'b1);
    n = 0; guard = 0;
    while (n < 3 && guard < 60) begin
      step();
      guard++;
      if (obj_ack) begin obj_req = 1'b0; n++; end
      if (cpu_ack) begin cpu_cs  = 1'b0; n++; end
      if (ss_ack)  begin ss_req  = 1'b0; n++; end
    end
    obj_req = 1'b0; cpu_cs = 1'b0; ss_req = 1'b0;
    check("arb3_acks", n, 3);
    step();

    // obj_req held continuously against a waiting CPU, in both modes
    for (int m = 1; m >= 0; m--) begin
      mode = 2'(m);
      cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_ds_n = 2'b00; cpu_addr = 12'h300;
      obj_req = 1'b1; obj_addr = 12'h301; obj_code = 14'h0155;
      for (int k = 0; k < 4; k++) push(0, (m == 1) ? 20'h09655 : 20'h00155, 1'b1);
      push(1, 20'h03C3C, 1'b1);
      nobj = 0; done = 1'b0; guard = 0;
      while (!done && guard < 100) begin
        step();
        guard++;
        if (cpu_ack) done = 1'b1;
        else if (obj_ack) nobj++;
      end
      obj_req = 1'b0; cpu_cs = 1'b0;
      if (!done) check("starve_timeout", cpu_ack, 1);
      check("starve_obj_grants", nobj, 4);
      step();
    end

    // reset during the ACC cycle of a savestate write
    ss_req = 1'b1; ss_we = 1'b1; ss_addr = 12'h250; ss_wdata = 8'h77;
    step();
    check("abort_we_acc", ram_we, 1);
    #2 reset_n = 1'b0;
    #1 check("abort_we_async", ram_we, 0);
    ss_req = 1'b0; ss_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_ack", {obj_ack, cpu_ack, ss_ack}, 0);
    check("abort_ss_rdata", ss_rdata, 0);
    check("abort_cpu_dout", cpu_dout, 0);
    check("abort_obj_code_out", obj_code_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    do_ss(1'b0, 12'h250, 8'h00, 8'h11, 1'b1, "post_rst_lat");
    check("abort_mem", mem[12'h250], 8'h11);
    check("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
